// File: rtl/next_grant_gen_pkg.sv
// Shared arbiter defaults, common to next_grant_gen and the downstream grant_request stage.
package next_grant_gen_pkg;

    localparam int ARB_CHANNELS       = 8;
    localparam int ARB_WIDTH          = 32;
    localparam int ARB_MAX_WEIGHT     = 16;
    localparam int ARB_DEFAULT_WEIGHT = 4;

endpackage : next_grant_gen_pkg

// File: rtl/next_grant_gen_rr_pick.sv
// Round-robin pick: lowest-index candidate at or above ptr_i, else lowest overall.
module rr_pick
    import next_grant_gen_pkg::*;
#(
    parameter int n  = ARB_CHANNELS,
    parameter int iw = $clog2(n)
) (
    input  logic [n-1:0]  cand_i,
    input  logic [iw-1:0] ptr_i,
    output logic [n-1:0]  pick_o
);

    logic [n-1:0] upper;
    logic [n-1:0] src;

    always_comb begin
        upper = '0;
        for (int i = 0; i < n; i++) begin
            upper[i] = cand_i[i] && (i >= int'(ptr_i));
        end
    end

    // Fall back to the full candidate set when nothing sits at or above the pointer.
    assign src    = (upper != '0) ? upper : cand_i;
    assign pick_o = src & (~src + {{(n-1){1'b0}}, 1'b1});

endmodule : rr_pick

// File: rtl/next_grant_gen.sv
// Weighted round-robin candidate generator: proposes the next one-hot grant and the
// weight of the channel currently being serviced.
module next_grant_gen
    import next_grant_gen_pkg::*;
#(
    parameter int channels       = ARB_CHANNELS,
    parameter int width          = ARB_WIDTH,
    parameter int max_weight     = ARB_MAX_WEIGHT,
    parameter int default_weight = ARB_DEFAULT_WEIGHT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [channels-1:0]         request,
    input  logic [channels-1:0]         priorities,
    input  logic [channels-1:0]         grant,
    input  logic                        cfg_wr_en,
    input  logic [$clog2(channels)-1:0] cfg_wr_addr,
    input  logic [width-1:0]            cfg_wr_data,
    output logic [channels-1:0]         next_grant,
    output logic [width-1:0]            weight,
    output logic                        grant_err
);

    localparam int IDX_W = $clog2(channels);

    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [channels-1:0] next_grant_q, prev_grant_q;
    logic [width-1:0]    weight_q, weight_d;
    logic                grant_err_q, grant_err_d;
    logic [width-1:0]    tbl_q [channels];

    logic [channels-1:0] cand, pick, grant_low, wr_sel;
    logic [IDX_W-1:0]    grant_idx, ng_idx, rd_idx;
    logic                new_grant, rd_en, wr_hit;
    logic [width-1:0]    wr_val;

    assign cand = ((request & priorities) != '0) ? (request & priorities) : request;

    rr_pick #(.n(channels), .iw(IDX_W)) u_pick (
        .cand_i (cand),
        .ptr_i  (ptr_q),
        .pick_o (pick)
    );

    // Descending scan so the lowest set bit is the last assignment to stick.
    always_comb begin
        grant_idx = '0;
        ng_idx    = '0;
        for (int i = channels - 1; i >= 0; i--) begin
            if (grant[i])        grant_idx = IDX_W'(i);
            if (next_grant_q[i]) ng_idx    = IDX_W'(i);
        end
    end

    assign grant_low   = grant & (~grant + {{(channels-1){1'b0}}, 1'b1});
    assign grant_err_d = grant_err_q | ((grant & ~grant_low) != '0);
    assign new_grant   = (grant != '0) && (grant != prev_grant_q);
    assign ptr_d       = !new_grant ? ptr_q :
                         (grant_idx == IDX_W'(channels - 1)) ? '0 : grant_idx + 1'b1;

    assign wr_hit = cfg_wr_en && (int'(cfg_wr_addr) < channels);
    assign wr_val = (cfg_wr_data == '0)                ? width'(1) :
                    (cfg_wr_data > width'(max_weight)) ? width'(max_weight) : cfg_wr_data;

    for (genvar gi = 0; gi < channels; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_hit && (cfg_wr_addr == IDX_W'(gi));
    end

    // The live grant takes precedence; otherwise look ahead to our own candidate.
    assign rd_en    = (grant != '0) || (next_grant_q != '0);
    assign rd_idx   = (grant != '0) ? grant_idx : ng_idx;
    assign weight_d = !rd_en                         ? weight_q :
                      (wr_hit && cfg_wr_addr == rd_idx) ? wr_val : tbl_q[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            next_grant_q <= '0;
            prev_grant_q <= '0;
            weight_q     <= '0;
            grant_err_q  <= 1'b0;
            for (int i = 0; i < channels; i++) begin
                tbl_q[i] <= width'(default_weight);
            end
        end else begin
            ptr_q        <= ptr_d;
            next_grant_q <= pick;
            prev_grant_q <= grant;
            weight_q     <= weight_d;
            grant_err_q  <= grant_err_d;
            for (int i = 0; i < channels; i++) begin
                if (wr_sel[i]) tbl_q[i] <= wr_val;
            end
        end
    end

    assign next_grant = next_grant_q;
    assign weight     = weight_q;
    assign grant_err  = grant_err_q;

endmodule : next_grant_gen

// File: doc/next_grant_gen.md
NEXT_GRANT_GEN -- requirements
Module: next_grant_gen

Interface
REQ-001 Parameter channels, default 8, number of requesters.
REQ-002 Parameter width, default 32, weight word width.
REQ-003 Parameter max_weight, default 16, largest storable weight.
REQ-004 Parameter default_weight, default 4, per-channel weight after reset.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 request  in  channels  raw per-channel requests.
REQ-008 priorities  in  channels  1 = channel is in the high-priority class.
REQ-009 grant  in  channels  grant currently issued by the downstream grant_request stage.
REQ-010 cfg_wr_en  in  1  weight-table write strobe.
REQ-011 cfg_wr_addr  in  $clog2(channels)  weight-table index.
REQ-012 cfg_wr_data  in  width  weight value to write.
REQ-013 next_grant  out  channels  registered one-hot candidate (or zero) fed to grant_request.
REQ-014 weight  out  width  registered weight of the channel being serviced.
REQ-015 grant_err  out  1  sticky flag; grant seen with more than one bit set.

Function
REQ-016 Block SHALL hold a rotation pointer ptr (0..channels-1) and a weight table of channels entries.
REQ-017 Candidate set SHALL be request & priorities when that is nonzero, else request.
REQ-018 Winner SHALL be the lowest-index candidate with index >= ptr; if none, the lowest-index candidate overall (wrap-around).
REQ-019 next_grant SHALL be the one-hot winner registered each cycle (latency 1 from request/priorities/ptr); all-zero when the candidate set is empty.
REQ-020 A new grant SHALL be detected when grant != 0 and grant != its previous-cycle value.
REQ-021 On a new grant with index g, ptr SHALL become g+1, wrapping to 0 past channels-1, effective for the next_grant computed in the following cycle.
REQ-022 A grant held constant over multiple cycles SHALL NOT move ptr again.
REQ-023 weight SHALL register table[index(grant)] when grant != 0, else table[index(next_grant)], else hold its value when both are zero.
REQ-024 On a multi-bit grant, index SHALL be that of the lowest set bit; grant_err SHALL set and stay set until reset.
REQ-025 Table writes SHALL clamp: data 0 stored as 1; data > max_weight stored as max_weight.
REQ-026 A write and a weight read of the same entry in the same cycle SHALL yield the new value on weight one cycle later (write-first).
REQ-027 cfg_wr_addr >= channels SHALL be ignored.
REQ-028 Request deassertion in the same cycle as a new grant SHALL still advance ptr.

Reset
REQ-029 While reset is high at posedge clk: ptr = 0, next_grant = 0, weight = 0, grant_err = 0, previous-grant register = 0, every table entry = default_weight.
REQ-030 Reset asserted mid-operation SHALL take effect on the same edge, overriding any concurrent grant or cfg write.

Structure
REQ-031 channels, width, max_weight and default_weight defaults SHALL live in the shared arbiter package, which is also used by grant_request.
REQ-032 The pointer-masked lowest-index search SHALL be a combinational sub-module rr_pick, instantiated once per candidate class or shared via a mux.

Verification
REQ-033 Reset, then request=8'b1000_0001, no grant -> next_grant=8'b0000_0001 one cycle later; weight=4.
REQ-034 grant=8'b0000_0001 held 5 cycles with request=8'b1000_0001 -> ptr=1 once; next_grant=8'b1000_0000; it is not advanced again.
REQ-035 ptr=7, grant=8'b1000_0000 new -> ptr wraps to 0; with request=8'hFF, next_grant=8'b0000_0001.
REQ-036 request=8'hFF, priorities=8'b0010_0000, ptr=0 -> next_grant=8'b0010_0000.
REQ-037 Write addr 3 data 0, then 40 -> table[3]=1, then 16; same-cycle write/read of addr 3 -> weight shows the written value next cycle.
REQ-038 grant=8'b0000_0110 -> grant_err=1, ptr=2; reset mid-count -> all outputs 0, table back to 4.
